requisita_ebulidor: RTL and testbench

- Initiator side of the boiler handshake: main control unit pulses iniciar, this block drives liga_ebulidor/zera_ebulidor to the boiler controller and waits for fim_ebulidor or timeout_ebulidor.
- Retries on timeout up to N_TENTATIVAS attempts, enforces a post-boil settle delay, then reports pronto (success) or erro (failure).
- Sits between the coffee-machine main FSM and the boiler controller.

---
 rtl/requisita_ebulidor_pkg.sv | 25 ++
 rtl/contador_m.sv | 32 +++
 rtl/requisita_ebulidor.sv | 118 +++++++++++
 tb/tb_requisita_ebulidor.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/requisita_ebulidor_pkg.sv
// Shared state encodings for the control-unit FSMs and the debug display decoder.
package requisita_ebulidor_pkg;

  // Width of the state code shown on db_estado
  localparam int W_ESTADO  = 4;
  localparam int N_ESTADOS = 9;

  typedef logic [W_ESTADO-1:0] estado_t;

  localparam estado_t INICIAL = 4'd0;
  localparam estado_t PREPARA = 4'd1;
  localparam estado_t LIGA    = 4'd2;
  localparam estado_t AGUARDA = 4'd3;
  localparam estado_t ESPERA  = 4'd4;
  localparam estado_t FIM     = 4'd5;
  localparam estado_t FALHA   = 4'd6;
  localparam estado_t ERRO    = 4'd7;
  localparam estado_t CANCELA = 4'd8;

  // Busy everywhere except the two resting states
  function automatic logic estado_ocupado(input estado_t e);
    return (e != INICIAL) && (e != ERRO);
  endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M counter with synchronous clear; fim flags the last count (M-1).
module contador_m #(
  parameter int M = 50000000,
  parameter int N = 26
) (
  input  logic clock,
  input  logic reset,
  input  logic zera_s,
  input  logic conta,
  output logic fim
);

  logic [N-1:0] contagem_reg;

  // Count while enabled, wrapping after M-1; synchronous clear has priority
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contagem_reg <= '0;
    end else if (zera_s) begin
      contagem_reg <= '0;
    end else if (conta) begin
      if (contagem_reg == N'(M - 1)) begin
        contagem_reg <= '0;
      end else begin
        contagem_reg <= contagem_reg + N'(1);
      end
    end
  end

  assign fim = (contagem_reg == N'(M - 1));

endmodule

// File: rtl/requisita_ebulidor.sv
// Initiator side of the boiler handshake: clears and starts the boiler,
// waits for completion or watchdog, retries on timeout, then settles before
// reporting success (pronto) or giving up (erro).
module requisita_ebulidor
  import requisita_ebulidor_pkg::*;
#(
  parameter int N_TENTATIVAS = 3,
  parameter int T_ESPERA     = 50000000,
  parameter int W_ESPERA     = 26
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic                cancelar,
  input  logic                fim_ebulidor,
  input  logic                timeout_ebulidor,
  output logic                liga_ebulidor,
  output logic                zera_ebulidor,
  output logic                ocupado,
  output logic                pronto,
  output logic                erro,
  output logic [1:0]          tentativas,
  output logic [W_ESTADO-1:0] db_estado
);

  estado_t        estado_reg;
  estado_t        estado_next;
  logic [1:0]     tentativas_reg;
  logic [1:0]     tentativas_next;
  logic           fim_espera;
  logic [N_ESTADOS-1:0] estado_oh;

  // Settle timer: runs only in ESPERA and sits at zero everywhere else,
  // so every entry into ESPERA starts from a fresh count.
  contador_m #(
    .M (T_ESPERA),
    .N (W_ESPERA)
  ) u_espera (
    .clock  (clock),
    .reset  (reset),
    .zera_s (estado_reg != ESPERA),
    .conta  (estado_reg == ESPERA),
    .fim    (fim_espera)
  );

  // State and attempt counter registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_reg     <= INICIAL;
      tentativas_reg <= 2'd0;
    end else begin
      estado_reg     <= estado_next;
      tentativas_reg <= tentativas_next;
    end
  end

  // Next-state logic; cancelar preempts every busy state that can still act
  always_comb begin
    estado_next     = estado_reg;
    tentativas_next = tentativas_reg;
    case (estado_reg)
      INICIAL, ERRO: begin
        if (iniciar) begin
          estado_next     = PREPARA;
          tentativas_next = 2'd0;
        end
      end
      PREPARA: estado_next = cancelar ? CANCELA : LIGA;
      LIGA:    estado_next = cancelar ? CANCELA : AGUARDA;
      AGUARDA: begin
        if (cancelar) begin
          estado_next = CANCELA;
        end else if (fim_ebulidor) begin
          estado_next = ESPERA;
        end else if (timeout_ebulidor) begin
          estado_next = FALHA;
        end
      end
      ESPERA: begin
        if (cancelar) begin
          estado_next = CANCELA;
        end else if (fim_espera) begin
          estado_next = FIM;
        end
      end
      FIM:     estado_next = INICIAL;
      FALHA: begin
        if (cancelar) begin
          // Abort leaves the failure count as it stood
          estado_next = CANCELA;
        end else begin
          tentativas_next = (tentativas_reg == 2'd3) ? 2'd3 : tentativas_reg + 2'd1;
          if (int'(tentativas_reg) + 1 < N_TENTATIVAS) begin
            estado_next = LIGA;
          end else begin
            estado_next = ERRO;
          end
        end
      end
      CANCELA: estado_next = INICIAL;
      default: estado_next = INICIAL;
    endcase
  end

  // One-hot decode of the registered state feeding the Moore outputs
  for (genvar gi = 0; gi < N_ESTADOS; gi++) begin : g_dec
    assign estado_oh[gi] = (estado_reg == W_ESTADO'(gi));
  end

  assign zera_ebulidor = estado_oh[PREPARA] | estado_oh[FALHA] | estado_oh[CANCELA];
  assign liga_ebulidor = estado_oh[LIGA];
  assign pronto        = estado_oh[FIM];
  assign erro          = estado_oh[ERRO];
  assign ocupado       = estado_ocupado(estado_reg);
  assign tentativas    = tentativas_reg;
  assign db_estado     = estado_reg;

endmodule

// File: tb/tb_requisita_ebulidor.sv
// Bench for requisita_ebulidor: a request-level model expands each scenario
// into a per-cycle trace of inputs and expected outputs, then the trace is
// replayed against the design.
module tb_requisita_ebulidor;

  localparam int T_ESP = 4;
  localparam int NT    = 3;

  localparam logic [3:0] D_INI = 4'd0, D_PREP = 4'd1, D_LIGA = 4'd2, D_AGU = 4'd3,
                         D_ESP = 4'd4, D_FIM = 4'd5, D_FAL = 4'd6, D_ERR = 4'd7,
                         D_CAN = 4'd8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0, cancelar = 1'b0, fim_ebulidor = 1'b0, timeout_ebulidor = 1'b0;
  logic       liga_ebulidor, zera_ebulidor, ocupado, pronto, erro;
  logic [1:0] tentativas;
  logic [3:0] db_estado;

  requisita_ebulidor #(
    .N_TENTATIVAS (NT),
    .T_ESPERA     (T_ESP),
    .W_ESPERA     (3)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .iniciar          (iniciar),
    .cancelar         (cancelar),
    .fim_ebulidor     (fim_ebulidor),
    .timeout_ebulidor (timeout_ebulidor),
    .liga_ebulidor    (liga_ebulidor),
    .zera_ebulidor    (zera_ebulidor),
    .ocupado          (ocupado),
    .pronto           (pronto),
    .erro             (erro),
    .tentativas       (tentativas),
    .db_estado        (db_estado)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic ini; logic can; logic fim; logic tmo;
  } in_t;

  typedef struct packed {
    logic liga; logic zera; logic ocup; logic pronto; logic erro;
    logic [1:0] tent; logic [3:0] db;
  } out_t;

  typedef struct {
    int         nfail;
    bit         both;
    int         wt;
    logic [3:0] cst;
    int         cnth;
    int         idle_after;
    logic [1:0] exp_tent;
    logic       exp_erro;
    int         exp_pronto;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  int   pronto_seen;
  in_t  in_q[$];
  out_t exp_q[$];
  out_t rest;

  function automatic out_t mk(logic [3:0] db, logic [1:0] tent, logic liga, logic zera,
                              logic pr, logic ocup, logic er);
    out_t o;
    o.liga = liga; o.zera = zera; o.ocup = ocup; o.pronto = pr; o.erro = er;
    o.tent = tent; o.db = db;
    return o;
  endfunction

  // Random inputs that the current state must ignore; ev allows fim/timeout
  function automatic in_t noise(bit ev);
    in_t n;
    n.ini = 1'($urandom_range(0, 1));
    n.can = 1'b0;
    n.fim = ev ? 1'($urandom_range(0, 1)) : 1'b0;
    n.tmo = ev ? 1'($urandom_range(0, 1)) : 1'b0;
    return n;
  endfunction

  task automatic push(out_t o, in_t i);
    exp_q.push_back(o);
    in_q.push_back(i);
  endtask

  // One request: nfail timeouts first, then success unless attempts run out.
  // wt < 0 picks a random quiet wait per attempt.
  task automatic build(int nfail, bit both, int wt);
    in_t s;
    s = noise(1);
    s.ini = 1'b1;
    s.can = 1'($urandom_range(0, 1));
    push(rest, s);
    push(mk(D_PREP, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), noise(1));
    for (int a = 0; a < NT; a++) begin
      int w;
      logic [1:0] ta;
      w  = (wt < 0) ? int'($urandom_range(0, 6)) : wt;
      ta = 2'(a);
      push(mk(D_LIGA, ta, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0), noise(1));
      for (int k = 0; k < w; k++) push(mk(D_AGU, ta, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), noise(0));
      s = noise(0);
      if (a < nfail) begin
        s.tmo = 1'b1;
      end else begin
        s.fim = 1'b1;
        s.tmo = both;
      end
      push(mk(D_AGU, ta, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), s);
      if (a < nfail) begin
        push(mk(D_FAL, ta, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), noise(1));
        if (a + 1 >= NT) begin
          rest = mk(D_ERR, 2'(a + 1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
          break;
        end
      end else begin
        for (int k = 0; k < T_ESP; k++) push(mk(D_ESP, ta, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), noise(1));
        push(mk(D_FIM, ta, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), noise(1));
        rest = mk(D_INI, ta, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        break;
      end
    end
  endtask

  // Abort the request in the nth cycle spent in state st: the trace is cut
  // there and replaced by one clearing cycle, then idle with the count kept.
  task automatic add_cancel(logic [3:0] st, int nth, output bit hit);
    int seen;
    int p;
    logic [1:0] tc;
    in_t c;
    seen = 0;
    hit  = 1'b0;
    p    = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].db == st) begin
        seen++;
        if (seen == nth) begin
          p   = i;
          hit = 1'b1;
          break;
        end
      end
    end
    if (hit) begin
      tc = exp_q[p].tent;
      c = in_q[p];
      c.can = 1'b1;
      in_q[p] = c;
      while (exp_q.size() > p + 1) begin
        void'(exp_q.pop_back());
        void'(in_q.pop_back());
      end
      c = noise(1);
      c.can = 1'($urandom_range(0, 1));
      push(mk(D_CAN, tc, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), c);
      rest = mk(D_INI, tc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic idle(int n);
    in_t s;
    for (int i = 0; i < n; i++) begin
      s = noise(1);
      s.ini = 1'b0;
      s.can = 1'($urandom_range(0, 1));
      push(rest, s);
    end
  endtask

  // Replay the trace: called at posedge+1, checks then drives each cycle
  task automatic play(int limit);
    int n;
    out_t d;
    n = (exp_q.size() < limit) ? exp_q.size() : limit;
    for (int i = 0; i < n; i++) begin
      d = {liga_ebulidor, zera_ebulidor, ocupado, pronto, erro, tentativas, db_estado};
      total++;
      if (d !== exp_q[i]) begin
        bad++;
        $display("FAIL trace[%0d] actual=%b required=%b (liga zera ocup pronto erro tent db)",
                 i, d, exp_q[i]);
      end
      if (pronto === 1'b1) pronto_seen++;
      iniciar          = in_q[i].ini;
      cancelar         = in_q[i].can;
      fim_ebulidor     = in_q[i].fim;
      timeout_ebulidor = in_q[i].tmo;
      @(posedge clock);
      #1;
    end
    exp_q.delete();
    in_q.delete();
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] outs_now();
    return 32'({liga_ebulidor, zera_ebulidor, ocupado, pronto, erro, tentativas, db_estado});
  endfunction

  vec_t vecs[7];

  initial begin
    bit hit;
    int n;
    vecs[0] = '{0, 1'b0, 10, 4'd0, 0, 3,  2'd0, 1'b0, 1};  // plain success
    vecs[1] = '{1, 1'b0, 5,  4'd0, 0, 2,  2'd1, 1'b0, 1};  // one retry
    vecs[2] = '{3, 1'b0, 2,  4'd0, 0, 20, 2'd3, 1'b1, 0};  // exhaustion, erro held
    vecs[3] = '{0, 1'b0, 1,  4'd0, 0, 2,  2'd0, 1'b0, 1};  // restart out of erro
    vecs[4] = '{0, 1'b1, 3,  4'd0, 0, 2,  2'd0, 1'b0, 1};  // fim and timeout together
    vecs[5] = '{0, 1'b0, 2,  D_ESP, 2, 3, 2'd0, 1'b0, 0};  // cancel in 2nd settle cycle
    vecs[6] = '{2, 1'b0, 3,  D_AGU, 6, 2, 2'd1, 1'b0, 0};  // cancel during 2nd attempt

    repeat (2) @(posedge clock);
    #1;
    chk("reset_outputs", outs_now(), 32'd0);
    reset = 1'b1;
    rest  = '0;

    for (int v = 0; v < 7; v++) begin
      pronto_seen = 0;
      build(vecs[v].nfail, vecs[v].both, vecs[v].wt);
      if (vecs[v].cst != 4'd0) add_cancel(vecs[v].cst, vecs[v].cnth, hit);
      idle(vecs[v].idle_after);
      n = exp_q.size();
      play(n);
      $display("vec %0d: nto=%0d both=%0d wait=%0d cancel_st=%0d cycles=%0d",
               v, vecs[v].nfail, vecs[v].both, vecs[v].wt, vecs[v].cst, n);
      chk($sformatf("vec%0d_tent", v), 32'(tentativas), 32'(vecs[v].exp_tent));
      chk($sformatf("vec%0d_erro", v), 32'(erro), 32'(vecs[v].exp_erro));
      chk($sformatf("vec%0d_pronto", v), pronto_seen, vecs[v].exp_pronto);
    end

    for (int r = 0; r < 40; r++) begin
      int nf;
      bit bo;
      nf = $urandom_range(0, 3);
      bo = 1'($urandom_range(0, 1));
      hit = 1'b0;
      build(nf, bo, -1);
      if ($urandom_range(0, 3) == 0) add_cancel(4'($urandom_range(1, 4)), $urandom_range(1, 3), hit);
      idle($urandom_range(0, 3));
      n = exp_q.size();
      play(n);
      $display("rnd %0d: nto=%0d both=%0d cancel=%0d cycles=%0d", r, nf, bo, hit, n);
    end

    // Asynchronous reset in the middle of AGUARDA, between clock edges
    build(0, 1'b0, 10);
    play(5);
    iniciar = 1'b0; cancelar = 1'b0; fim_ebulidor = 1'b0; timeout_ebulidor = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    chk("async_reset_immediate", outs_now(), 32'd0);
    @(posedge clock);
    #1;
    chk("async_reset_held", outs_now(), 32'd0);
    reset = 1'b1;
    rest  = '0;
    pronto_seen = 0;
    build(0, 1'b0, 1);
    idle(2);
    n = exp_q.size();
    play(n);
    $display("post-reset request: cycles=%0d", n);
    chk("post_reset_pronto", pronto_seen, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench watchdog expired");
  end

endmodule
